// File: rtl/collision_event_handler.sv
// Collision event handler: turns per-frame collision signals into shot kills,
// enemy-hit pulses, saturating score, lives bookkeeping and the game FSM.
module collision_event_handler #(
  parameter int LIVES_INIT   = 3,
  parameter int GHOST_FRAMES = 60,
  parameter int ENEMY_POINTS = 10,
  parameter int HD_POINTS    = 5,
  parameter int SCORE_MAX    = 999
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       startGame,
  input  logic [2:0] ShotEnemyCollision,
  input  logic [2:0] ShotBoxCollision,
  input  logic       ShotHeadsDownCollision,
  input  logic       TowerEnemyHUCollision,
  input  logic       towerPlayerCollision,
  output logic [2:0] shotKill,
  output logic       enemyHit,
  output logic [9:0] score,
  output logic [1:0] lives,
  output logic       ghostMode,
  output logic [1:0] gameState
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PLAY      = 2'd1,
    S_GHOST     = 2'd2,
    S_GAME_OVER = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] ghost_cnt;

  logic [2:0] shot_seen;
  logic [2:0] hit_shots;
  logic       hd_seen;
  logic       player_dmg;
  logic       enemy_hit_seen;

  logic [2:0]  shot_coll;
  logic        any_enemy_hit;
  logic        dmg_now;
  logic [2:0]  shot_seen_base;
  logic        enemy_hit_base;
  logic [11:0] frame_points;
  logic [9:0]  score_next;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

  // 12-bit sum clamped to SCORE_MAX
  function automatic logic [9:0] sat_add(input logic [9:0] s, input logic [11:0] a);
    logic [11:0] sum;
    sum = {2'b00, s} + a;
    return (sum > 12'(SCORE_MAX)) ? 10'(SCORE_MAX) : sum[9:0];
  endfunction

  assign shot_coll      = ShotEnemyCollision | ShotBoxCollision;
  assign any_enemy_hit  = (|ShotEnemyCollision) | ShotHeadsDownCollision;
  assign dmg_now        = towerPlayerCollision | TowerEnemyHUCollision;
  // On a frame-start clk the latches behave as already cleared (new frame)
  assign shot_seen_base = startOfFrame ? 3'b000 : shot_seen;
  assign enemy_hit_base = startOfFrame ? 1'b0 : enemy_hit_seen;
  assign frame_points   = 12'(popcount3(hit_shots)) * 12'(ENEMY_POINTS)
                        + (hd_seen ? 12'(HD_POINTS) : 12'd0);
  assign score_next     = sat_add(score, frame_points);
  assign gameState      = state;

  // Frame latches and once-per-frame pulses
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shot_seen      <= 3'b000;
      hit_shots      <= 3'b000;
      hd_seen        <= 1'b0;
      player_dmg     <= 1'b0;
      enemy_hit_seen <= 1'b0;
      shotKill       <= 3'b000;
      enemyHit       <= 1'b0;
    end else begin
      shotKill       <= shot_coll & ~shot_seen_base;
      shot_seen      <= shot_seen_base | shot_coll;
      enemyHit       <= any_enemy_hit & ~enemy_hit_base;
      enemy_hit_seen <= enemy_hit_base | any_enemy_hit;
      hit_shots      <= (startOfFrame ? 3'b000 : hit_shots) | ShotEnemyCollision;
      hd_seen        <= (startOfFrame ? 1'b0 : hd_seen) | ShotHeadsDownCollision;
      player_dmg     <= (startOfFrame ? 1'b0 : player_dmg) | (dmg_now & (state == S_PLAY));
    end
  end

  // Game FSM with frame evaluation on the startOfFrame clk
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= S_IDLE;
      score     <= 10'd0;
      lives     <= 2'd0;
      ghost_cnt <= 8'd0;
      ghostMode <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_GAME_OVER: begin
          if (startGame) begin
            state     <= S_PLAY;
            score     <= 10'd0;
            lives     <= 2'(LIVES_INIT);
            ghostMode <= 1'b0;
          end
        end
        S_PLAY: begin
          if (startOfFrame) begin
            score <= score_next;
            if (player_dmg) begin
              if (lives == 2'd1) begin
                lives <= 2'd0;
                state <= S_GAME_OVER;
              end else begin
                lives     <= lives - 2'd1;
                ghost_cnt <= 8'(GHOST_FRAMES);
                state     <= S_GHOST;
                ghostMode <= 1'b1;
              end
            end
          end
        end
        S_GHOST: begin
          if (startOfFrame) begin
            score     <= score_next;
            ghost_cnt <= ghost_cnt - 8'd1;
            if (ghost_cnt == 8'd1) begin
              state     <= S_PLAY;
              ghostMode <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_event_handler.sv
// Bench for collision_event_handler: vector table, hand sequences for the
// multi-frame corners, and random stimulus against a frame-level model.
module tb_collision_event_handler;

  localparam int LIVES_INIT   = 3;
  localparam int GHOST_FRAMES = 60;
  localparam int ENEMY_POINTS = 10;
  localparam int HD_POINTS    = 5;
  localparam int SCORE_MAX    = 999;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame, startGame;
  logic [2:0] se, sb;
  logic       hd, te, tp;
  logic [2:0] shotKill;
  logic       enemyHit;
  logic [9:0] score;
  logic [1:0] lives;
  logic       ghostMode;
  logic [1:0] gameState;

  collision_event_handler #(
    .LIVES_INIT(LIVES_INIT), .GHOST_FRAMES(GHOST_FRAMES), .ENEMY_POINTS(ENEMY_POINTS),
    .HD_POINTS(HD_POINTS), .SCORE_MAX(SCORE_MAX)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startGame(startGame),
    .ShotEnemyCollision(se), .ShotBoxCollision(sb), .ShotHeadsDownCollision(hd),
    .TowerEnemyHUCollision(te), .towerPlayerCollision(tp),
    .shotKill(shotKill), .enemyHit(enemyHit), .score(score), .lives(lives),
    .ghostMode(ghostMode), .gameState(gameState)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  int  m_state, m_score, m_lives, m_ghost;
  bit  f_killed[3], f_hit[3];
  bit  f_hd, f_dmg, f_reported;
  bit  [2:0] e_kill;
  bit  e_eh;

  task automatic model_reset();
    m_state = 0; m_score = 0; m_lives = 0; m_ghost = 0;
    for (int i = 0; i < 3; i++) begin f_killed[i] = 0; f_hit[i] = 0; end
    f_hd = 0; f_dmg = 0; f_reported = 0; e_kill = 0; e_eh = 0;
  endtask

  task automatic model_update();
    int ns, nsc, nl, ng, hits;
    ns = m_state; nsc = m_score; nl = m_lives; ng = m_ghost;
    if (m_state == 0 || m_state == 3) begin
      if (startGame) begin ns = 1; nsc = 0; nl = LIVES_INIT; end
    end else if (startOfFrame) begin
      hits = 0;
      for (int i = 0; i < 3; i++) if (f_hit[i]) hits++;
      nsc = m_score + hits * ENEMY_POINTS + (f_hd ? HD_POINTS : 0);
      if (nsc > SCORE_MAX) nsc = SCORE_MAX;
      if (m_state == 1 && f_dmg) begin
        if (m_lives == 1) begin nl = 0; ns = 3; end
        else begin nl = m_lives - 1; ng = GHOST_FRAMES; ns = 2; end
      end else if (m_state == 2) begin
        ng = m_ghost - 1;
        if (ng == 0) ns = 1;
      end
    end
    if (startOfFrame) begin
      for (int i = 0; i < 3; i++) begin f_killed[i] = 0; f_hit[i] = 0; end
      f_hd = 0; f_dmg = 0; f_reported = 0;
    end
    for (int i = 0; i < 3; i++) begin
      e_kill[i] = (se[i] || sb[i]) && !f_killed[i];
      if (se[i] || sb[i]) f_killed[i] = 1;
      if (se[i]) f_hit[i] = 1;
    end
    e_eh = ((se != 0) || hd) && !f_reported;
    if ((se != 0) || hd) f_reported = 1;
    if (hd) f_hd = 1;
    if (m_state == 1 && (tp || te)) f_dmg = 1;
    m_state = ns; m_score = nsc; m_lives = nl; m_ghost = ng;
  endtask

  task automatic compare_model();
    check("shotKill", shotKill, e_kill);
    check("enemyHit", enemyHit, e_eh);
    check("score", score, m_score);
    check("lives", lives, m_lives);
    check("gameState", gameState, m_state);
    check("ghostMode", ghostMode, (m_state == 2));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    startOfFrame = 0; startGame = 0; se = 0; sb = 0; hd = 0; te = 0; tp = 0;
  endtask

  task automatic sof_tick();
    startOfFrame = 1; tick(); startOfFrame = 0;
  endtask

  // one frame: a couple of quiet clks then the frame start
  task automatic frame();
    tick(); tick(); sof_tick();
  endtask

  task automatic wait_ghost_out();
    for (int k = 0; k < GHOST_FRAMES; k++) frame();
  endtask

  task automatic damage_frame();
    tp = 1; tick(); tp = 0; sof_tick();
  endtask

  typedef struct {
    bit sof; bit sg; bit [2:0] se; bit [2:0] sb; bit hd; bit tp;
    bit [2:0] ek; bit eh; int sc; int lv; int st;
  } vec_t;
  vec_t tbl[16];

  initial begin
    //           sof sg  se      sb      hd  tp  ek      eh  sc  lv st
    tbl[0]  = '{0, 1, 3'b000, 3'b000, 0, 0, 3'b000, 0,  0, 3, 1};
    tbl[1]  = '{1, 0, 3'b000, 3'b000, 0, 0, 3'b000, 0,  0, 3, 1};
    tbl[2]  = '{0, 0, 3'b101, 3'b000, 0, 0, 3'b101, 1,  0, 3, 1};
    tbl[3]  = '{0, 0, 3'b101, 3'b000, 0, 0, 3'b000, 0,  0, 3, 1};
    tbl[4]  = '{0, 0, 3'b101, 3'b000, 0, 0, 3'b000, 0,  0, 3, 1};
    tbl[5]  = '{0, 0, 3'b101, 3'b000, 0, 0, 3'b000, 0,  0, 3, 1};
    tbl[6]  = '{0, 0, 3'b101, 3'b000, 0, 0, 3'b000, 0,  0, 3, 1};
    tbl[7]  = '{1, 0, 3'b000, 3'b000, 0, 0, 3'b000, 0, 20, 3, 1};
    tbl[8]  = '{0, 0, 3'b010, 3'b000, 1, 0, 3'b010, 1, 20, 3, 1};
    tbl[9]  = '{0, 0, 3'b000, 3'b100, 0, 0, 3'b100, 0, 20, 3, 1};
    tbl[10] = '{0, 0, 3'b000, 3'b100, 1, 0, 3'b000, 0, 20, 3, 1};
    tbl[11] = '{1, 0, 3'b001, 3'b000, 0, 0, 3'b001, 1, 35, 3, 1};
    tbl[12] = '{0, 0, 3'b001, 3'b000, 0, 0, 3'b000, 0, 35, 3, 1};
    tbl[13] = '{1, 0, 3'b000, 3'b000, 0, 0, 3'b000, 0, 45, 3, 1};
    tbl[14] = '{0, 0, 3'b000, 3'b000, 0, 1, 3'b000, 0, 45, 3, 1};
    tbl[15] = '{1, 0, 3'b000, 3'b000, 0, 0, 3'b000, 0, 45, 2, 2};

    // reset state
    idle_inputs();
    resetN = 0;
    model_reset();
    #1;
    compare_model();
    check("rst_state", gameState, 0);
    check("rst_lives", lives, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1;

    // vector table: start, scoring frames, new-frame collision, first damage
    for (int i = 0; i < 16; i++) begin
      startOfFrame = tbl[i].sof; startGame = tbl[i].sg;
      se = tbl[i].se; sb = tbl[i].sb; hd = tbl[i].hd; tp = tbl[i].tp;
      tick();
      check("vec_shotKill", shotKill, tbl[i].ek);
      check("vec_enemyHit", enemyHit, tbl[i].eh);
      check("vec_score", score, tbl[i].sc);
      check("vec_lives", lives, tbl[i].lv);
      check("vec_state", gameState, tbl[i].st);
      check("vec_ghost", ghostMode, (tbl[i].st == 2));
    end
    idle_inputs();

    // ghost: damage ignored, exit exactly after GHOST_FRAMES frame starts
    tp = 1;
    for (int k = 0; k < GHOST_FRAMES - 1; k++) frame();
    check("ghost_hold_state", gameState, 2);
    check("ghost_hold_lives", lives, 2);
    tp = 0;
    frame();
    check("ghost_exit_state", gameState, 1);
    check("ghost_exit_mode", ghostMode, 0);
    check("ghost_exit_lives", lives, 2);

    // second damage, then fatal damage with a scoring hit in the same frame
    damage_frame();
    check("dmg2_lives", lives, 1);
    wait_ghost_out();
    se = 3'b001; tick(); se = 0;
    damage_frame();
    check("over_state", gameState, 3);
    check("over_lives", lives, 0);
    check("over_score", score, 55);
    se = 3'b111; hd = 1; tick(); se = 0; hd = 0;
    sof_tick();
    check("over_frozen", score, 55);
    startGame = 1; tick(); startGame = 0;
    check("restart_state", gameState, 1);
    check("restart_lives", lives, 3);
    check("restart_score", score, 0);

    // saturation at SCORE_MAX
    for (int k = 0; k < 28; k++) begin
      se = 3'b111; hd = 1; tick(); se = 0; hd = 0; sof_tick();
    end
    check("sat_980", score, 980);
    se = 3'b001; hd = 1; tick(); se = 0; hd = 0; sof_tick();
    check("sat_995", score, 995);
    se = 3'b111; tick(); se = 0; sof_tick();
    check("sat_999", score, 999);
    se = 3'b111; hd = 1; tick(); se = 0; hd = 0; sof_tick();
    check("sat_hold", score, 999);

    // asynchronous reset in the middle of GHOST
    damage_frame();
    check("pre_rst_ghost", gameState, 2);
    tick();
    resetN = 0;
    model_reset();
    #1;
    compare_model();
    check("midrst_state", gameState, 0);
    check("midrst_score", score, 0);
    check("midrst_ghost", ghostMode, 0);
    @(negedge clk);
    resetN = 1;

    // random stimulus against the model
    begin
      int flen, pos;
      flen = 4; pos = 0;
      for (int c = 0; c < 6000; c++) begin
        startOfFrame = (pos == flen);
        if (pos == flen) begin pos = 0; flen = $urandom_range(2, 6); end
        else pos++;
        startGame = ($urandom_range(0, 15) == 0);
        se = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
        sb = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
        hd = ($urandom_range(0, 5) == 0);
        te = ($urandom_range(0, 40) == 0);
        tp = ($urandom_range(0, 40) == 0);
        tick();
      end
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
